// File: rtl/i2c_target_rx_if.sv
// Register-write side of the I2C write-only target: strobe, pointer, data and status.
interface i2c_target_rx_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       busy;
    logic [7:0] nack_cnt;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output busy,
        output nack_cnt
    );

    modport slave (
        input reg_addr,
        input reg_wdata,
        input reg_we,
        input busy,
        input nack_cnt
    );
endinterface

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, register pointer byte, then data bytes
// written at the pointer, which auto-increments. Open-drain ACK on sda.
module i2c_target_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h68
) (
    input  logic            clk_50,
    input  logic            state_reset,
    input  logic            scl,
    inout  wire             sda,
    i2c_target_rx_if.master regs
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       reg_we_q, reg_we_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic [7:0] nack_cnt_q, nack_cnt_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_w;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk_50 or negedge state_reset) begin
        if (!state_reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & ~sda_prev_q & sda_s2_q;
    assign byte_w    = {shreg_q[6:0], sda_s2_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        nack_cnt_d  = nack_cnt_q;
        // Post-write increment lands one cycle after the strobe so reg_addr stays stable with it
        ptr_d       = reg_we_q ? ptr_q + 8'd1 : ptr_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, DATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_w;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (byte_w[7:1] == SLAVE_ADDR && !byte_w[0]) begin
                                    state_d = ADDR_ACK;
                                end else begin
                                    state_d    = IGNORE;
                                    nack_cnt_d = sat_inc8(nack_cnt_q);
                                end
                            end else if (state_q == REG) begin
                                ptr_d   = byte_w;
                                state_d = REG_ACK;
                            end else begin
                                reg_we_d    = 1'b1;
                                reg_addr_d  = ptr_q;
                                reg_wdata_d = byte_w;
                                state_d     = DATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    // First falling edge pulls sda low, the next one releases and moves on
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (state_q == ADDR_ACK) begin
                                state_d = REG;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge state_reset) begin
        if (!state_reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= 8'h00;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            nack_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            nack_cnt_q  <= nack_cnt_d;
        end
    end

    assign sda            = sda_oe_q ? 1'b0 : 1'bz;
    assign regs.reg_addr  = reg_addr_q;
    assign regs.reg_wdata = reg_wdata_q;
    assign regs.reg_we    = reg_we_q;
    assign regs.busy      = busy_q;
    assign regs.nack_cnt  = nack_cnt_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, directed and random transactions
// scored against a byte-level model of the target's behaviour.
module tb_i2c_target_rx;

    localparam int Q = 8;
    localparam logic [7:0] ADDR_W = {7'h68, 1'b0};

    logic clk_50 = 1'b0;
    logic state_reset = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic in_ack = 1'b0;
    wire  sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_target_rx_if rif ();

    i2c_target_rx #(.SLAVE_ADDR(7'h68)) dut (
        .clk_50      (clk_50),
        .state_reset (state_reset),
        .scl         (m_scl),
        .sda         (sda_bus),
        .regs        (rif)
    );

    always #10 clk_50 = ~clk_50;

    int n_tests = 0;
    int n_fail = 0;
    int we_long = 0;
    int drive_bad = 0;
    int dut_low_tot = 0;
    logic we_prev = 1'b0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    int obs_rd = 0;
    int exp_nack = 0;
    logic [7:0] tx [0:15];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_50) begin
        #1;
        if (rif.reg_we) obs_q.push_back({rif.reg_addr, rif.reg_wdata});
        if (rif.reg_we && we_prev) we_long++;
        we_prev = rif.reg_we;
        if (m_sda && sda_bus === 1'b0) begin
            dut_low_tot++;
            if (m_scl && !in_ack) drive_bad++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; wait_clk(Q);
            m_scl = 1'b1; wait_clk(2 * Q);
            m_scl = 1'b0; wait_clk(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        send_bits(b, 8);
        m_sda = 1'b1; wait_clk(Q);
        in_ack = 1'b1; m_scl = 1'b1; wait_clk(Q);
        ack = (sda_bus === 1'b0);
        wait_clk(Q);
        m_scl = 1'b0; in_ack = 1'b0; wait_clk(Q);
    endtask

    task automatic drain_writes();
        logic [15:0] e;
        check_eq("wr_cnt", 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check_eq("wr_addr_data", 32'(obs_q[obs_rd]), 32'(e));
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    // Model: address byte decides ACK for the whole transfer; 2nd byte loads the
    // pointer; each later byte is written at the pointer, which then advances mod 256.
    task automatic run_txn(input int n, input int partial, input bit do_stop);
        bit addressed;
        bit ack;
        logic [7:0] ptr;
        int low0;
        addressed = (tx[0] == ADDR_W);
        if (!addressed && exp_nack < 255) exp_nack++;
        ptr = 8'h00;
        low0 = dut_low_tot;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            write_byte(tx[i], ack);
            check_eq("ack", 32'(ack), 32'(addressed));
            if (addressed && i == 1) ptr = tx[1];
            if (addressed && i >= 2) begin
                exp_q.push_back({ptr, tx[i]});
                ptr = ptr + 8'd1;
            end
            if (i == 0) check_eq("busy_addr", 32'(rif.busy), 32'(addressed));
        end
        if (partial > 0) send_bits(8'($urandom_range(0, 255)), partial);
        if (do_stop) begin
            i2c_stop();
            wait_clk(4);
            check_eq("busy_stop", 32'(rif.busy), 32'd0);
        end
        if (!addressed) check_eq("nack_quiet", 32'(dut_low_tot - low0), 32'd0);
        check_eq("nack_cnt", 32'(rif.nack_cnt), 32'(exp_nack));
        drain_writes();
    endtask

    initial begin
        bit ack;
        int n, partial;
        bit stp;

        wait_clk(5);
        check_eq("rst_busy", 32'(rif.busy), 32'd0);
        check_eq("rst_we", 32'(rif.reg_we), 32'd0);
        check_eq("rst_addr", 32'(rif.reg_addr), 32'd0);
        check_eq("rst_wdata", 32'(rif.reg_wdata), 32'd0);
        check_eq("rst_nack", 32'(rif.nack_cnt), 32'd0);
        check_eq("rst_sda", 32'(sda_bus), 32'd1);
        state_reset = 1'b1;
        wait_clk(5);

        tx[0] = 8'hD0; tx[1] = 8'h80; tx[2] = 8'hF0;
        run_txn(3, 0, 1'b1);
        tx[0] = 8'hA0; tx[1] = 8'h80;
        run_txn(2, 0, 1'b1);
        tx[0] = 8'hD0; tx[1] = 8'hFF; tx[2] = 8'h11; tx[3] = 8'h22;
        run_txn(4, 0, 1'b1);
        tx[0] = 8'hD1; tx[1] = 8'h55;
        run_txn(2, 0, 1'b0);
        tx[0] = 8'hD0;
        run_txn(1, 0, 1'b1);
        tx[0] = 8'hD0; tx[1] = 8'h10;
        run_txn(2, 4, 1'b0);
        tx[0] = 8'hD0; tx[1] = 8'h20; tx[2] = 8'h55;
        run_txn(3, 0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            tx[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : ADDR_W;
            n = $urandom_range(1, 5);
            for (int i = 1; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
            partial = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            stp = ($urandom_range(0, 3) != 0);
            run_txn(n, partial, stp);
        end
        i2c_stop();
        wait_clk(4);
        check_eq("busy_final", 32'(rif.busy), 32'd0);

        // Reset asserted while the target holds sda low for the pointer-byte ACK
        i2c_start();
        write_byte(8'hD0, ack);
        check_eq("ack_pre_rst", 32'(ack), 32'd1);
        send_bits(8'h33, 8);
        m_sda = 1'b1;
        check_eq("ack_driving", 32'(sda_bus), 32'd0);
        check_eq("busy_pre_rst", 32'(rif.busy), 32'd1);
        #3;
        state_reset = 1'b0;
        #1;
        check_eq("rst_mid_sda", 32'(sda_bus), 32'd1);
        check_eq("rst_mid_busy", 32'(rif.busy), 32'd0);
        check_eq("rst_mid_we", 32'(rif.reg_we), 32'd0);
        check_eq("rst_mid_addr", 32'(rif.reg_addr), 32'd0);
        check_eq("rst_mid_wdata", 32'(rif.reg_wdata), 32'd0);
        check_eq("rst_mid_nack", 32'(rif.nack_cnt), 32'd0);
        exp_nack = 0;
        wait_clk(3);
        state_reset = 1'b1;
        wait_clk(3);

        // Without a START the target must stay silent
        write_byte(8'hD0, ack);
        check_eq("no_start_ack", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(4);
        drain_writes();

        tx[0] = 8'hD0; tx[1] = 8'h42; tx[2] = 8'h99;
        run_txn(3, 0, 1'b1);

        check_eq("we_width", 32'(we_long), 32'd0);
        check_eq("sda_high_phase", 32'(drive_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h68, 7-bit target address matched against the first byte after START.
REQ-002 clk_50  input  1  system clock, 50 MHz; all logic synchronous to it except reset.
REQ-003 state_reset  input  1  reset, asynchronous, active-low.
REQ-004 scl  input  1  I2C serial clock from the bus master.
REQ-005 sda  inout  1  I2C serial data, open-drain; the block only drives 1'b0 or 1'bz.
REQ-006 reg_addr  output  8  register pointer for the current write.
REQ-007 reg_wdata  output  8  received data byte.
REQ-008 reg_we  output  1  single-cycle write strobe.
REQ-009 busy  output  1  high while this target is addressed (ACKed address until STOP/START).
REQ-010 nack_cnt  output  8  count of NACKed address bytes, saturating at 8'hFF.

Function
REQ-011 scl and sda shall each pass through a 2-flop synchronizer, reset value 1, before any use; edges shall be detected against the previous synchronized sample.
REQ-012 START is defined as synced sda falling while synced scl = 1; STOP is defined as synced sda rising while synced scl = 1.
REQ-013 States shall be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
REQ-014 START in any state shall go to ADDR, clear the bit counter, release sda, and drop busy (repeated START included).
REQ-015 STOP in any state shall go to IDLE, release sda, and drop busy; a partially received byte shall be discarded with no reg_we.
REQ-016 In ADDR/REG/DATA, the block shall sample sda on each synced scl rising edge, MSB first, using a 3-bit bit counter; the 8th sample completes the byte.
REQ-017 ADDR complete: if byte[7:1] == SLAVE_ADDR and byte[0] == 0, go to ADDR_ACK; otherwise go to IGNORE and increment nack_cnt.
REQ-018 ACK states: on the first synced scl falling edge after the byte completes, drive sda = 0; hold it through the ACK clock high phase; release on the next scl falling edge.
REQ-019 ADDR_ACK release -> REG with busy = 1; REG_ACK release -> DATA; DATA_ACK release -> DATA.
REQ-020 REG complete: load the byte into the register pointer and always ACK.
REQ-021 DATA complete: reg_addr = pointer and reg_wdata = byte, both valid while reg_we = 1.
REQ-022 reg_we shall be high for exactly one clk_50 cycle, the cycle after the 8th scl rising edge is detected.
REQ-023 The pointer shall increment by 1, mod 256 (8'hFF -> 8'h00), on the cycle after reg_we; a data byte shall always be ACKed.
REQ-024 IGNORE shall never drive sda and shall leave only on START or STOP.
REQ-025 sda shall never be driven in IDLE or during any scl high phase other than the ACK bit.

Reset
REQ-026 While state_reset = 0: state = IDLE, sda = z (immediately, asynchronous), reg_we = 0, busy = 0, reg_addr = 8'h00, reg_wdata = 8'h00, nack_cnt = 8'h00, pointer = 8'h00, synchronizers = 1.
REQ-027 After reset deasserts, bus activity shall be ignored until the first START.
REQ-028 Reset asserted mid-transfer shall abort with no reg_we pulse.

Verification
REQ-029 Sequence START, 0xD0, 0x80, 0xF0, STOP -> three ACKs; one reg_we pulse with reg_addr = 8'h80 and reg_wdata = 8'hF0; busy returns to 0 after STOP.
REQ-030 Sequence START, 0xA0, 0x80, STOP -> sda never driven low; reg_we stays 0; nack_cnt = 1.
REQ-031 Sequence START, 0xD0, 0xFF, 0x11, 0x22, STOP -> writes (8'hFF, 8'h11) then (8'h00, 8'h22) (pointer wrap).
REQ-032 Sequence START, 0xD1 -> NACK, state IGNORE, nack_cnt increments; a following START, 0xD0 -> ACK.
REQ-033 START, 0xD0, 0x10, four data bits, then repeated START, 0xD0, 0x20, 0x55, STOP -> only one write (8'h20, 8'h55).
REQ-034 state_reset = 0 asserted during an ACK low phase -> sda goes to z in the same cycle; no reg_we; all outputs at reset values.
